// File: rtl/pwm_pkg.sv
// Constants and types shared between the PWM generator and the PWM decoder.
package pwm_pkg;

    localparam int PWM_WIDTH = 8;

    // Largest reportable duty; an all-high window counts one more than this.
    localparam logic [PWM_WIDTH-1:0] PWM_SAT_MAX = PWM_WIDTH'((1 << PWM_WIDTH) - 1);

    typedef enum logic [0:0] {
        WARMUP  = 1'b0,
        MEASURE = 1'b1
    } dec_state_t;

endpackage

// File: rtl/pwm_decoder_sync_bit.sv
// Single-bit multi-flop synchronizer with synchronous active-low reset.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/pwm_decoder.sv
// Recovers the duty value of a PWM waveform by counting high samples over a
// free-running window of 2^WIDTH clocks.
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int WIDTH       = PWM_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             stable
);

    // An all-high window counts 2^WIDTH, which must read as full scale.
    function automatic logic [WIDTH-1:0] sat(input logic [WIDTH:0] t);
        return t[WIDTH] ? {WIDTH{1'b1}} : t[WIDTH-1:0];
    endfunction

    logic             s;
    logic [WIDTH-1:0] wcnt;
    logic [WIDTH:0]   hcnt;
    dec_state_t       state;
    logic             have_prev;

    logic             last_p0;
    logic [WIDTH:0]   total_p0;
    logic [WIDTH-1:0] meas_p0;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (din),
        .q  (s)
    );

    // Stage p0: window bookkeeping on the synchronized sample.
    assign last_p0  = (wcnt == {WIDTH{1'b1}});
    assign total_p0 = hcnt + {{WIDTH{1'b0}}, s};
    assign meas_p0  = sat(total_p0);

    // Stage p1: registered report, one cycle after the last window sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wcnt      <= '0;
            hcnt      <= '0;
            state     <= WARMUP;
            have_prev <= 1'b0;
            dout      <= '0;
            valid     <= 1'b0;
            stable    <= 1'b0;
        end else begin
            wcnt  <= wcnt + 1'b1;
            valid <= 1'b0;
            if (last_p0) begin
                hcnt <= '0;
                // The first window is polluted by synchronizer fill; drop it.
                if (state == WARMUP) begin
                    state <= MEASURE;
                end else begin
                    dout      <= meas_p0;
                    valid     <= 1'b1;
                    stable    <= have_prev && (meas_p0 == dout);
                    have_prev <= 1'b1;
                end
            end else begin
                hcnt <= total_p0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed testbench for pwm_decoder driven by a behavioural PWM generator.
module tb_pwm_decoder;

    logic       clk;
    logic       rst;
    logic       din;
    logic [7:0] dout;
    logic       valid;
    logic       stable;

    int n_cmp;
    int n_err;

    // Behavioural generator: din = (gcnt < duty), gcnt free-running.
    logic [7:0] gcnt;
    int         duty;
    logic       gen_en;
    logic       const_mode;
    logic       const_val;

    pwm_decoder #(
        .WIDTH      (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .dout  (dout),
        .valid (valid),
        .stable(stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst) gcnt = 8'd0;
        else if (gen_en) gcnt = gcnt + 8'd1;
        if (const_mode) din = const_val;
        else din = gen_en && (int'(gcnt) < duty);
    endtask

    // The last edge with rst=0 is edge 0; the next tick is edge 1.
    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) tick();
        rst = 1'b1;
    endtask

    task automatic run_to_report(input int budget, output int waited, output logic ok);
        waited = 0;
        ok = 1'b0;
        while (waited < budget && !ok) begin
            tick();
            waited++;
            if (valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        const_mode = 1'b1; const_val = 1'b1; gen_en = 1'b0;
        do_reset(3);
        n_cmp++; if (dout !== 8'd0) begin n_err++; $display("FAIL reset_dout got=%0d want=0", dout); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", valid); end
        n_cmp++; if (stable !== 1'b0) begin n_err++; $display("FAIL reset_stable got=%b want=0", stable); end
    endtask

    task automatic test_duty30();
        logic early;
        logic extra;
        logic [1:0] exp_stable;
        const_mode = 1'b0; gen_en = 1'b1; duty = 30;
        do_reset(2);
        early = 1'b0;
        extra = 1'b0;
        for (int n = 1; n <= 1030; n++) begin
            tick();
            if (n < 512 && valid !== 1'b0) early = 1'b1;
            if (n == 512 || n == 768 || n == 1024) begin
                exp_stable = (n == 512) ? 2'd0 : 2'd1;
                n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL d30_valid n=%0d got=%b want=1", n, valid); end
                n_cmp++; if (dout !== 8'd30) begin n_err++; $display("FAIL d30_dout n=%0d got=%0d want=30", n, dout); end
                n_cmp++; if (stable !== exp_stable[0]) begin n_err++; $display("FAIL d30_stable n=%0d got=%b want=%b", n, stable, exp_stable[0]); end
            end else if (n > 512 && valid !== 1'b0) begin
                extra = 1'b1;
            end
        end
        n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL d30_early_valid got=%b want=0", early); end
        n_cmp++; if (extra !== 1'b0) begin n_err++; $display("FAIL d30_extra_valid got=%b want=0", extra); end
    endtask

    task automatic test_const(input logic lvl, input logic [7:0] exp);
        int   w;
        logic ok;
        const_mode = 1'b1; const_val = lvl; gen_en = 1'b0;
        do_reset(2);
        for (int r = 0; r < 3; r++) begin
            run_to_report((r == 0) ? 600 : 300, w, ok);
            n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL const%0b_timeout r=%0d got=%b want=1", lvl, r, ok); end
            n_cmp++; if (dout !== exp) begin n_err++; $display("FAIL const%0b_dout r=%0d got=%0d want=%0d", lvl, r, dout, exp); end
            n_cmp++; if (stable !== (r != 0)) begin n_err++; $display("FAIL const%0b_stable r=%0d got=%b want=%b", lvl, r, stable, (r != 0)); end
        end
    endtask

    task automatic test_duty255();
        int   w;
        logic ok;
        const_mode = 1'b0; gen_en = 1'b1; duty = 255;
        do_reset(2);
        for (int r = 0; r < 2; r++) begin
            run_to_report(600, w, ok);
            n_cmp++; if (ok !== 1'b1 || dout !== 8'd255) begin n_err++; $display("FAIL d255_dout r=%0d got=%0d want=255 ok=%b", r, dout, ok); end
        end
    endtask

    task automatic test_duty_change();
        int         w;
        logic       ok;
        logic [7:0] r1;
        logic       s1;
        const_mode = 1'b0; gen_en = 1'b1; duty = 100;
        do_reset(2);
        run_to_report(600, w, ok);
        run_to_report(300, w, ok);
        n_cmp++; if (ok !== 1'b1 || dout !== 8'd100 || stable !== 1'b1) begin n_err++; $display("FAIL chg_pre got=%0d/%b want=100/1", dout, stable); end
        for (int i = 0; i < 256 && gcnt != 8'd128; i++) tick();
        duty = 200;
        run_to_report(300, w, ok);
        r1 = dout; s1 = stable;
        n_cmp++; if (ok !== 1'b1 || r1 < 8'd100 || r1 > 8'd200) begin n_err++; $display("FAIL chg_r1_range got=%0d want=100..200", r1); end
        n_cmp++; if (s1 !== (r1 == 8'd100)) begin n_err++; $display("FAIL chg_r1_stable got=%b want=%b", s1, (r1 == 8'd100)); end
        run_to_report(300, w, ok);
        n_cmp++; if (ok !== 1'b1 || dout !== 8'd200) begin n_err++; $display("FAIL chg_r2_dout got=%0d want=200", dout); end
        n_cmp++; if (stable !== (r1 == 8'd200)) begin n_err++; $display("FAIL chg_r2_stable got=%b want=%b", stable, (r1 == 8'd200)); end
        run_to_report(300, w, ok);
        n_cmp++; if (ok !== 1'b1 || dout !== 8'd200 || stable !== 1'b1) begin n_err++; $display("FAIL chg_r3 got=%0d/%b want=200/1", dout, stable); end
    endtask

    task automatic test_reset_mid();
        int   w;
        logic ok;
        const_mode = 1'b0; gen_en = 1'b1; duty = 35;
        do_reset(2);
        run_to_report(600, w, ok);
        run_to_report(300, w, ok);
        n_cmp++; if (ok !== 1'b1 || dout !== 8'd35 || stable !== 1'b1) begin n_err++; $display("FAIL rmid_pre got=%0d/%b want=35/1", dout, stable); end
        repeat (100) tick();
        do_reset(3);
        n_cmp++; if (dout !== 8'd0 || valid !== 1'b0 || stable !== 1'b0) begin n_err++; $display("FAIL rmid_cleared got=%0d/%b/%b want=0/0/0", dout, valid, stable); end
        run_to_report(600, w, ok);
        n_cmp++; if (ok !== 1'b1 || w != 512) begin n_err++; $display("FAIL rmid_latency got=%0d want=512", w); end
        n_cmp++; if (dout !== 8'd35 || stable !== 1'b0) begin n_err++; $display("FAIL rmid_first got=%0d/%b want=35/0", dout, stable); end
        run_to_report(300, w, ok);
        n_cmp++; if (ok !== 1'b1 || w != 256) begin n_err++; $display("FAIL rmid_period got=%0d want=256", w); end
        n_cmp++; if (dout !== 8'd35 || stable !== 1'b1) begin n_err++; $display("FAIL rmid_second got=%0d/%b want=35/1", dout, stable); end
    endtask

    task automatic test_phase();
        int   w;
        logic ok;
        const_mode = 1'b0; gen_en = 1'b0; duty = 100;
        do_reset(2);
        repeat (77) tick();
        gen_en = 1'b1;
        for (int r = 0; r < 3; r++) begin
            run_to_report(600, w, ok);
            n_cmp++; if (ok !== 1'b1 || dout !== 8'd100) begin n_err++; $display("FAIL phase_dout r=%0d got=%0d want=100", r, dout); end
            n_cmp++; if (stable !== (r != 0)) begin n_err++; $display("FAIL phase_stable r=%0d got=%b want=%b", r, stable, (r != 0)); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        din = 1'b0;
        gcnt = 8'd0;
        duty = 0;
        gen_en = 1'b0;
        const_mode = 1'b1;
        const_val = 1'b0;

        test_reset();
        test_duty30();
        test_const(1'b0, 8'd0);
        test_const(1'b1, 8'd255);
        test_duty255();
        test_duty_change();
        test_reset_mid();
        test_phase();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
